// File: rtl/router_spi_pkg.sv
// Shared types and default parameters for the SPI transmit master.
package router_spi_pkg;

   localparam int unsigned SPI_SIZE_DEFAULT    = 8;
   localparam int unsigned SPI_CLK_DIV_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } spi_state_t;

endpackage : router_spi_pkg

// File: rtl/spi_clk_div.sv
// Half-period counter: counts 0..CLK_DIV-1 while enabled and flags the terminal count.
module spi_clk_div #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_tick_c
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] r_cnt;

   assign o_tick_c = i_en && (r_cnt == CW'(CLK_DIV - 1));

   // Counter advances only while enabled and wraps at terminal count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (o_tick_c) r_cnt <= '0;
         else          r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule : spi_clk_div

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: shifts one frame out on mosi while capturing miso.
module spi_master_tx
   import router_spi_pkg::*;
#(
   parameter int unsigned size    = SPI_SIZE_DEFAULT,
   parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [size-1:0] tx_data,
   input  logic            tx_valid,
   output logic            tx_ready,
   output logic [size-1:0] rx_data,
   output logic            rx_valid,
   output logic            sclk,
   output logic            mosi,
   input  logic            miso,
   output logic            cs_n
);

   localparam int unsigned BW = $clog2(size + 1);

   spi_state_t      r_state, w_state_next;
   logic [size-1:0] r_tx_sh, w_tx_sh_next;
   logic [size-1:0] r_rx_sh, w_rx_sh_next;
   logic [size-1:0] r_rx_data, w_rx_data_next;
   logic [BW-1:0]   r_bit_cnt, w_bit_cnt_next;
   logic            r_sclk, w_sclk_next;
   logic            r_mosi, w_mosi_next;
   logic            r_cs_n, w_cs_n_next;
   logic            r_rx_valid, w_rx_valid_next;
   logic            r_tx_ready, w_tx_ready_next;
   logic            w_tick;

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk      (clk),
      .reset    (reset),
      .i_en     (r_state == ST_SHIFT),
      .o_tick_c (w_tick)
   );

   assign tx_ready = r_tx_ready;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign sclk     = r_sclk;
   assign mosi     = r_mosi;
   assign cs_n     = r_cs_n;

   // Next-state, shift and registered-output computation.
   always_comb begin
      w_state_next   = r_state;
      w_tx_sh_next   = r_tx_sh;
      w_rx_sh_next   = r_rx_sh;
      w_rx_data_next = r_rx_data;
      w_bit_cnt_next = r_bit_cnt;
      w_sclk_next    = r_sclk;

      case (r_state)
         ST_IDLE: begin
            if (tx_valid) begin
               w_state_next   = ST_SHIFT;
               w_tx_sh_next   = tx_data;
               w_bit_cnt_next = '0;
               w_sclk_next    = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (w_tick) begin
               w_sclk_next = ~r_sclk;
               if (!r_sclk) begin
                  // Rising sclk: capture miso and count the bit.
                  w_rx_sh_next   = {r_rx_sh[size-2:0], miso};
                  w_bit_cnt_next = r_bit_cnt + BW'(1);
               end else if (r_bit_cnt == BW'(size)) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_tx_sh_next = {r_tx_sh[size-2:0], 1'b0};
               end
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
            w_sclk_next  = 1'b0;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      // Outputs are registered, so derive them from the upcoming state.
      w_cs_n_next     = (w_state_next != ST_SHIFT);
      w_tx_ready_next = (w_state_next == ST_IDLE);
      w_rx_valid_next = (w_state_next == ST_DONE);
      w_mosi_next     = (w_state_next == ST_SHIFT) ? w_tx_sh_next[size-1] : 1'b0;
      if (w_state_next == ST_DONE) w_rx_data_next = w_rx_sh_next;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_tx_sh    <= '0;
         r_rx_sh    <= '0;
         r_rx_data  <= '0;
         r_bit_cnt  <= '0;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_cs_n     <= 1'b1;
         r_rx_valid <= 1'b0;
         r_tx_ready <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_tx_sh    <= w_tx_sh_next;
         r_rx_sh    <= w_rx_sh_next;
         r_rx_data  <= w_rx_data_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_sclk     <= w_sclk_next;
         r_mosi     <= w_mosi_next;
         r_cs_n     <= w_cs_n_next;
         r_rx_valid <= w_rx_valid_next;
         r_tx_ready <= w_tx_ready_next;
      end
   end

endmodule : spi_master_tx

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: one instance at CLK_DIV=4, one at CLK_DIV=1.
module tb_spi_master_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       sel;      // 0: CLK_DIV=4 instance, 1: CLK_DIV=1 instance
   logic       lb;       // miso looped to mosi
   logic       slv_bit;  // slave-driven miso when not looped back

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   logic       tx_valid0, tx_ready0, rx_valid0, sclk0, mosi0, miso0, cs_n0;
   logic [7:0] rx_data0;
   logic       tx_valid1, tx_ready1, rx_valid1, sclk1, mosi1, miso1, cs_n1;
   logic [7:0] rx_data1;

   assign tx_valid0 = tx_valid & ~sel;
   assign tx_valid1 = tx_valid & sel;
   assign miso0     = lb ? mosi0 : slv_bit;
   assign miso1     = lb ? mosi1 : slv_bit;

   spi_master_tx #(.size(8), .CLK_DIV(4)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid0),
      .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
      .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(cs_n0)
   );

   spi_master_tx #(.size(8), .CLK_DIV(1)) dut1 (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid1),
      .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1),
      .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1)
   );

   logic       tx_ready, rx_valid, sclk, mosi, cs_n;
   logic [7:0] rx_data;
   assign tx_ready = sel ? tx_ready1 : tx_ready0;
   assign rx_valid = sel ? rx_valid1 : rx_valid0;
   assign sclk     = sel ? sclk1     : sclk0;
   assign mosi     = sel ? mosi1     : mosi0;
   assign cs_n     = sel ? cs_n1     : cs_n0;
   assign rx_data  = sel ? rx_data1  : rx_data0;

   // Send one frame and observe it as a mode-0 slave would.
   task automatic run_frame(input logic [7:0] d, input logic [7:0] slv,
                            output logic [7:0] mosi_bits, output logic [7:0] rxd,
                            output int cs_cyc, output int lat, output int rises,
                            output bit mosi_any, output bit tog_all);
      logic prev_sclk, prev_mosi;
      mosi_bits = '0; rxd = '0; cs_cyc = 0; lat = -1; rises = 0;
      mosi_any = 0; tog_all = 1;
      for (int w = 0; w < 20 && !tx_ready; w++) @(negedge clk);
      @(negedge clk);
      tx_data = d; tx_valid = 1'b1; slv_bit = slv[7];
      @(posedge clk); #1;
      tx_valid = 1'b0;
      prev_sclk = 1'b0; prev_mosi = 1'b0;
      for (int c = 1; c < 400; c++) begin
         if (!cs_n) begin
            cs_cyc++;
            if (mosi) mosi_any = 1;
            if (c > 1 && sclk == prev_sclk) tog_all = 0;
         end
         if (sclk && !prev_sclk) begin
            mosi_bits = {mosi_bits[6:0], prev_mosi};
            rises++;
            if (rises < 8) slv_bit = slv[3'(7 - rises)];
         end
         if (rx_valid) begin
            lat = c; rxd = rx_data;
            break;
         end
         prev_sclk = sclk; prev_mosi = mosi;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b1; tx_valid = 1'b0; tx_data = '0; sel = 1'b0; lb = 1'b1; slv_bit = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
      checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk); end
      checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi); end
      checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
      checks++; if (cs_n1 !== 1'b1 || tx_ready1 !== 1'b1) begin errors++; $display("FAIL reset_div1 cs_n %b tx_ready %b want 1 1", cs_n1, tx_ready1); end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_loopback_a5;
      logic [7:0] mb, rxd; int cs_cyc, lat, rises; bit many, tog;
      sel = 1'b0; lb = 1'b1;
      run_frame(8'hA5, 8'h00, mb, rxd, cs_cyc, lat, rises, many, tog);
      checks++; if (mb !== 8'hA5) begin errors++; $display("FAIL a5_mosi_bits got %h want a5", mb); end
      checks++; if (cs_cyc != 64) begin errors++; $display("FAIL a5_cs_low got %0d want 64", cs_cyc); end
      checks++; if (lat != 65) begin errors++; $display("FAIL a5_latency got %0d want 65", lat); end
      checks++; if (rises != 8) begin errors++; $display("FAIL a5_sclk_rises got %0d want 8", rises); end
      checks++; if (rxd !== 8'hA5) begin errors++; $display("FAIL a5_rx_data got %h want a5", rxd); end
      @(posedge clk); #1;
      checks++; if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || tx_ready !== 1'b1) begin
         errors++; $display("FAIL a5_idle_after cs_n %b sclk %b mosi %b rdy %b want 1 0 0 1", cs_n, sclk, mosi, tx_ready);
      end
   endtask

   task automatic test_miso_one;
      logic [7:0] mb, rxd; int cs_cyc, lat, rises; bit many, tog;
      sel = 1'b0; lb = 1'b0;
      run_frame(8'h00, 8'hFF, mb, rxd, cs_cyc, lat, rises, many, tog);
      checks++; if (rxd !== 8'hFF) begin errors++; $display("FAIL one_rx_data got %h want ff", rxd); end
      checks++; if (many) begin errors++; $display("FAIL one_mosi_zero got high want 0"); end
   endtask

   task automatic test_back_to_back;
      int cyc, n, m;
      int acc[2];
      logic [7:0] rxv[2];
      sel = 1'b0; lb = 1'b1; cyc = 0; n = 0; m = 0;
      acc[0] = 0; acc[1] = 0; rxv[0] = '0; rxv[1] = '0;
      @(negedge clk);
      tx_data = 8'h3C; tx_valid = 1'b1;
      for (int g = 0; g < 400 && m < 2; g++) begin
         if (tx_ready && tx_valid && n < 2) begin acc[n] = cyc; n++; end
         @(posedge clk); cyc++; #1;
         if (n == 2) tx_valid = 1'b0;
         if (cyc == 10) tx_data = 8'hC3;
         if (rx_valid) begin if (m < 2) rxv[m] = rx_data; m++; end
         @(negedge clk);
      end
      tx_valid = 1'b0;
      checks++; if (n != 2 || acc[1] - acc[0] != 66) begin errors++; $display("FAIL b2b_spacing got %0d accepts gap %0d want 2 gap 66", n, acc[1] - acc[0]); end
      checks++; if (m != 2 || rxv[0] !== 8'h3C) begin errors++; $display("FAIL b2b_first got %0d frames %h want 2 3c", m, rxv[0]); end
      checks++; if (rxv[1] !== 8'hC3) begin errors++; $display("FAIL b2b_second got %h want c3", rxv[1]); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic [7:0] mb, rxd; int cs_cyc, lat, rises; bit many, tog;
      int rv_cnt, cs_low;
      sel = 1'b0; lb = 1'b1; rv_cnt = 0; cs_low = 0;
      @(negedge clk);
      tx_data = 8'($urandom); tx_valid = 1'b1;
      @(posedge clk); #1; tx_valid = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (cs_n !== 1'b1 || tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_abort cs_n %b rdy %b want 1 1", cs_n, tx_ready); end
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (rx_valid) rv_cnt++;
         if (!cs_n) cs_low++;
      end
      checks++; if (rv_cnt != 0 || cs_low != 0) begin errors++; $display("FAIL rstmid_quiet rx_valid %0d cs_low %0d want 0 0", rv_cnt, cs_low); end
      run_frame(8'h5A, 8'h00, mb, rxd, cs_cyc, lat, rises, many, tog);
      checks++; if (rxd !== 8'h5A || mb !== 8'h5A) begin errors++; $display("FAIL rstmid_next rx %h mosi %h want 5a 5a", rxd, mb); end
   endtask

   task automatic test_div1;
      logic [7:0] mb, rxd; int cs_cyc, lat, rises; bit many, tog;
      repeat (2) @(negedge clk);
      sel = 1'b1; lb = 1'b1;
      run_frame(8'h81, 8'h00, mb, rxd, cs_cyc, lat, rises, many, tog);
      checks++; if (cs_cyc != 16) begin errors++; $display("FAIL div1_cs_low got %0d want 16", cs_cyc); end
      checks++; if (!tog) begin errors++; $display("FAIL div1_toggle got stall want toggle every cycle"); end
      checks++; if (rxd !== 8'h81 || mb !== 8'h81) begin errors++; $display("FAIL div1_data rx %h mosi %h want 81 81", rxd, mb); end
      checks++; if (lat != 17) begin errors++; $display("FAIL div1_latency got %0d want 17", lat); end
      repeat (2) @(negedge clk);
      sel = 1'b0;
   endtask

   task automatic test_reset_accept;
      int cs_low;
      cs_low = 0; sel = 1'b0;
      @(negedge clk);
      reset = 1'b1; tx_valid = 1'b1; tx_data = 8'($urandom);
      @(posedge clk); #1;
      checks++; if (cs_n !== 1'b1 || tx_ready !== 1'b1) begin errors++; $display("FAIL rstacc_edge cs_n %b rdy %b want 1 1", cs_n, tx_ready); end
      @(negedge clk); reset = 1'b0; tx_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (!cs_n) cs_low++;
      end
      checks++; if (cs_low != 0) begin errors++; $display("FAIL rstacc_no_frame cs_low %0d want 0", cs_low); end
   endtask

   task automatic test_random;
      logic [7:0] mb, rxd, d, s; int cs_cyc, lat, rises, div; bit many, tog;
      for (int k = 0; k < 10; k++) begin
         repeat (2) @(negedge clk);
         sel = 1'($urandom_range(0, 1)); lb = 1'b0;
         div = sel ? 1 : 4;
         d = 8'($urandom); s = 8'($urandom);
         run_frame(d, s, mb, rxd, cs_cyc, lat, rises, many, tog);
         checks++; if (rxd !== s) begin errors++; $display("FAIL rnd%0d_rx got %h want %h", k, rxd, s); end
         checks++; if (mb !== d) begin errors++; $display("FAIL rnd%0d_mosi got %h want %h", k, mb, d); end
         checks++; if (cs_cyc != 16 * div || lat != 16 * div + 1 || rises != 8) begin
            errors++; $display("FAIL rnd%0d_timing cs %0d lat %0d rises %0d want %0d %0d 8", k, cs_cyc, lat, rises, 16 * div, 16 * div + 1);
         end
         repeat ($urandom_range(1, 6)) @(posedge clk);
         #1;
         checks++; if (rx_data !== s) begin errors++; $display("FAIL rnd%0d_hold got %h want %h", k, rx_data, s); end
      end
      @(negedge clk); sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_loopback_a5();
      test_miso_one();
      test_back_to_back();
      test_reset_mid();
      test_div1();
      test_reset_accept();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_spi_master_tx

// File: doc/spi_master_tx.md
SPI_MASTER_TX -- requirements
Module: spi_master_tx

Interface
REQ-001 Parameter: size, 8, frame width in bits (>=2).
REQ-002 Parameter: CLK_DIV, 4, clk cycles per SCLK half-period (>=1).
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: tx_data  input  size  frame to transmit, MSB first.
REQ-006 Port: tx_valid  input  1  tx_data holds a frame to send.
REQ-007 Port: tx_ready  output  1  block can accept a frame this cycle.
REQ-008 Port: rx_data  output  size  frame captured from miso during the last transfer.
REQ-009 Port: rx_valid  output  1  one-cycle pulse; rx_data is updated and valid.
REQ-010 Port: sclk  output  1  SPI clock, mode 0 (idle low, sample on rising edge).
REQ-011 Port: mosi  output  1  serial data to slave.
REQ-012 Port: miso  input  1  serial data from slave, synchronous to clk.
REQ-013 Port: cs_n  output  1  active-low slave select.

Function
REQ-014 States: IDLE, SHIFT, DONE; IDLE is the only state with tx_ready=1.
REQ-015 Accept occurs on a rising edge with tx_valid=1 and tx_ready=1; tx_data is latched into the shift register; state goes to SHIFT.
REQ-016 tx_valid while not in IDLE is ignored; tx_data is not sampled outside the accept edge.
REQ-017 In SHIFT: cs_n=0; mosi=current shift-register MSB; sclk starts low.
REQ-018 The half-period counter counts 0..CLK_DIV-1; at terminal count sclk toggles and the counter wraps to 0.
REQ-019 On each sclk low-to-high toggle, miso is shifted into the LSB of the receive register.
REQ-020 On each sclk high-to-low toggle, the transmit register shifts left by one, except after the last bit.
REQ-021 A bit counter counts rising sclk edges; after the size-th falling edge, state goes to DONE.
REQ-022 cs_n is low for exactly 2*size*CLK_DIV cycles per frame, starting the cycle after accept.
REQ-023 sclk has exactly size rising edges per frame.
REQ-024 In DONE (one cycle): cs_n=1, sclk=0, rx_valid=1, rx_data=receive register, tx_ready=0; next state is IDLE.
REQ-025 Accept-to-rx_valid latency is 2*size*CLK_DIV+1 cycles.
REQ-026 Minimum accept-to-accept spacing is 2*size*CLK_DIV+2 cycles.
REQ-027 rx_data holds its value until the next DONE.
REQ-028 In IDLE: cs_n=1, sclk=0, mosi=0.
REQ-029 CLK_DIV=1: sclk toggles every cycle; all rules above still hold.

Reset
REQ-030 Reset applies at the clock edge and overrides any other event on that edge, including an accept.
REQ-031 Reset values: state=IDLE, tx_ready=1, rx_valid=0, rx_data=0, sclk=0, mosi=0, cs_n=1, all counters=0.
REQ-032 Reset mid-frame aborts the frame: cs_n=1 the next cycle and no rx_valid is produced.

Structure
REQ-033 Shared package router_spi_pkg holds the state enumeration and the default values of size and CLK_DIV.
REQ-034 Sub-module spi_clk_div (half-period counter, CLK_DIV parameter, enable input, tick output) is instantiated once; shift/FSM logic stays in spi_master_tx.

Verification
REQ-035 size=8, CLK_DIV=4, miso looped to mosi, send 8'hA5 -> mosi bits 1,0,1,0,0,1,0,1 at rising sclk; cs_n low 64 cycles; rx_valid at cycle 65 after accept; rx_data=8'hA5.
REQ-036 miso tied 1, send 8'h00 -> rx_data=8'hFF; mosi=0 throughout the frame.
REQ-037 tx_valid held high with data 8'h3C then 8'hC3 -> two frames; accepts 66 cycles apart; 8'h3C (first frame) is not corrupted by the data change.
REQ-038 reset asserted 20 cycles into frame -> cs_n=1, tx_ready=1 the next cycle; no rx_valid; a following 8'h5A frame is correct.
REQ-039 CLK_DIV=1, loopback, send 8'h81 -> sclk toggles every cycle; cs_n low 16 cycles; rx_data=8'h81.
REQ-040 reset and an accept on the same edge -> reset wins; no frame starts and cs_n stays 1.
